// File: rtl/prog_mem_loader.sv
// Program memory responder with a streaming byte loader.
// Optional running checksum output enabled by defining PROG_MEM_CHECKSUM_EN.
module prog_mem_loader #(
  parameter int         DEPTH = 256,
  parameter logic [7:0] FILL  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic       strobe,
  output logic [7:0] dataRead,
  input  logic       ld_start,
  input  logic [7:0] ld_base,
  input  logic [8:0] ld_count,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       ld_busy,
  output logic       ld_done,
  output logic       rd_collision
`ifdef PROG_MEM_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} stateT;

  stateT      stateReg;
  logic [7:0] ptrReg;
  logic [8:0] remainingReg;
  logic       writeEn;

  logic [7:0] mem [0:DEPTH-1];

  assign writeEn = (stateReg == LOAD) && ld_valid;

  // RAM is deliberately left out of reset so it maps onto block RAM and keeps
  // bytes written before a reset.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[ptrReg] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg     <= IDLE;
      ptrReg       <= 8'h00;
      remainingReg <= 9'd0;
      ld_ready     <= 1'b0;
      ld_busy      <= 1'b0;
      ld_done      <= 1'b0;
      rd_collision <= 1'b0;
      dataRead     <= 8'h00;
    end else begin
      ld_done <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (ld_start) begin
            ptrReg       <= ld_base;
            remainingReg <= ld_count;
            ld_busy      <= 1'b1;
            if (ld_count == 9'd0) begin
              stateReg <= DONE;
              ld_done  <= 1'b1;
            end else begin
              stateReg <= LOAD;
              ld_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (ld_valid) begin
            ptrReg       <= ptrReg + 8'd1;
            remainingReg <= remainingReg - 9'd1;
            if (remainingReg == 9'd1) begin
              stateReg <= DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          stateReg <= IDLE;
          ld_busy  <= 1'b0;
        end
        default: begin
          stateReg <= IDLE;
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
        end
      endcase

      // A read racing an accepted write returns FILL; the write always wins.
      if (strobe) begin
        if (writeEn) begin
          dataRead     <= FILL;
          rd_collision <= 1'b1;
        end else begin
          dataRead <= mem[addr];
        end
      end
    end
  end

`ifdef PROG_MEM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= 8'h00;
    end else if ((stateReg == IDLE) && ld_start) begin
      checksum <= 8'h00;
    end else if (writeEn) begin
      checksum <= checksum + ld_data;
    end
  end
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed testbench for prog_mem_loader; checksum checks are active only
// when PROG_MEM_CHECKSUM_EN is defined.
module tb_prog_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr;
  logic       strobe;
  logic [7:0] dataRead;
  logic       ld_start;
  logic [7:0] ld_base;
  logic [8:0] ld_count;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_busy;
  logic       ld_done;
  logic       rd_collision;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int total = 0;
  int bad   = 0;

  prog_mem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .strobe       (strobe),
    .dataRead     (dataRead),
    .ld_start     (ld_start),
    .ld_base      (ld_base),
    .ld_count     (ld_count),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .ld_busy      (ld_busy),
    .ld_done      (ld_done),
    .rd_collision (rd_collision)
`ifdef PROG_MEM_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic startLoad(input logic [7:0] base, input logic [8:0] count);
    ld_start = 1'b1;
    ld_base  = base;
    ld_count = count;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic readChk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr   = a;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    chk(tag, {24'd0, dataRead}, {24'd0, exp});
  endtask

  // Byte pushed as the i-th element of the full-memory load.
  function automatic logic [7:0] fillByte(input int i);
    logic [7:0] b;
    b = i[7:0];
    return b ^ 8'hA5;
  endfunction

  function automatic logic [7:0] fillAt(input logic [7:0] a);
    logic [7:0] idx;
    idx = a - 8'h05;
    return fillByte(int'(idx));
  endfunction

  initial begin
    logic [7:0] csumExp;
    rst_n = 1'b0; addr = 8'h00; strobe = 1'b0;
    ld_start = 1'b0; ld_base = 8'h00; ld_count = 9'd0;
    ld_valid = 1'b0; ld_data = 8'h00;
    #1;
    chk("rst_dataRead", {24'd0, dataRead}, 32'h00);
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_busy", {31'd0, ld_busy}, 32'd0);
    chk("rst_done", {31'd0, ld_done}, 32'd0);
    chk("rst_coll", {31'd0, rd_collision}, 32'd0);
`ifdef PROG_MEM_CHECKSUM_EN
    chk("rst_csum", {24'd0, checksum}, 32'h00);
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic load
    startLoad(8'h10, 9'd3);
    chk("basic_ready", {31'd0, ld_ready}, 32'd1);
    chk("basic_busy", {31'd0, ld_busy}, 32'd1);
    pushByte(8'h31);
    pushByte(8'hC3);
    chk("basic_notdone", {31'd0, ld_done}, 32'd0);
    pushByte(8'hFF);
    chk("basic_done", {31'd0, ld_done}, 32'd1);
    chk("basic_ready_off", {31'd0, ld_ready}, 32'd0);
    chk("basic_busy_done", {31'd0, ld_busy}, 32'd1);
    tick();
    chk("basic_done_pulse", {31'd0, ld_done}, 32'd0);
    chk("basic_busy_off", {31'd0, ld_busy}, 32'd0);
    readChk("basic_rd10", 8'h10, 8'h31);
    readChk("basic_rd11", 8'h11, 8'hC3);
    readChk("basic_rd12", 8'h12, 8'hFF);
    addr = 8'h10;
    tick();
    chk("read_hold", {24'd0, dataRead}, 32'hFF);

    // Wrap-around
    startLoad(8'hFE, 9'd4);
    pushByte(8'hA1); pushByte(8'hA2); pushByte(8'hA3); pushByte(8'hA4);
    chk("wrap_done", {31'd0, ld_done}, 32'd1);
`ifdef PROG_MEM_CHECKSUM_EN
    csumExp = 8'hA1 + 8'hA2 + 8'hA3 + 8'hA4;
    chk("wrap_csum", {24'd0, checksum}, {24'd0, csumExp});
`else
    csumExp = 8'h00;
`endif
    tick();
`ifdef PROG_MEM_CHECKSUM_EN
    chk("wrap_csum_hold", {24'd0, checksum}, {24'd0, csumExp});
`endif
    readChk("wrap_rdFE", 8'hFE, 8'hA1);
    readChk("wrap_rdFF", 8'hFF, 8'hA2);
    readChk("wrap_rd00", 8'h00, 8'hA3);
    readChk("wrap_rd01", 8'h01, 8'hA4);

    // Zero count at an already-written address
    startLoad(8'h10, 9'd0);
    chk("zero_done", {31'd0, ld_done}, 32'd1);
    chk("zero_ready", {31'd0, ld_ready}, 32'd0);
    chk("zero_busy", {31'd0, ld_busy}, 32'd1);
`ifdef PROG_MEM_CHECKSUM_EN
    chk("zero_csum", {24'd0, checksum}, 32'h00);
`endif
    tick();
    chk("zero_done_off", {31'd0, ld_done}, 32'd0);
    chk("zero_busy_off", {31'd0, ld_busy}, 32'd0);
    readChk("zero_rd10", 8'h10, 8'h31);

    // Full count
    startLoad(8'h05, 9'd256);
    for (int i = 0; i < 255; i++) pushByte(fillByte(i));
    chk("full_255_done", {31'd0, ld_done}, 32'd0);
    chk("full_255_ready", {31'd0, ld_ready}, 32'd1);
    pushByte(fillByte(255));
    chk("full_done", {31'd0, ld_done}, 32'd1);
    chk("full_ready_off", {31'd0, ld_ready}, 32'd0);
    ld_valid = 1'b1; ld_data = 8'h00;
    tick();
    ld_valid = 1'b0;
    chk("full_idle_ready", {31'd0, ld_ready}, 32'd0);
    readChk("full_rd05", 8'h05, fillAt(8'h05));
    readChk("full_rd04", 8'h04, fillAt(8'h04));
    readChk("full_rd00", 8'h00, fillAt(8'h00));
    readChk("full_rd10", 8'h10, fillAt(8'h10));

    // Stalled stream with an ignored restart
    startLoad(8'h40, 9'd2);
    pushByte(8'h11);
    chk("stall_nd1", {31'd0, ld_done}, 32'd0);
    ld_start = 1'b1; ld_base = 8'h80; ld_count = 9'd5;
    addr = 8'h05; strobe = 1'b1;
    tick();
    ld_start = 1'b0; strobe = 1'b0;
    chk("stall_load_read", {24'd0, dataRead}, {24'd0, fillAt(8'h05)});
    chk("stall_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    chk("stall_nd2", {31'd0, ld_done}, 32'd0);
    pushByte(8'h22);
    chk("stall_done", {31'd0, ld_done}, 32'd1);
    tick();
    readChk("stall_rd40", 8'h40, 8'h11);
    readChk("stall_rd41", 8'h41, 8'h22);
    readChk("stall_rd80", 8'h80, fillAt(8'h80));
    chk("stall_nocoll", {31'd0, rd_collision}, 32'd0);

    // Collision
    startLoad(8'h50, 9'd1);
    addr = 8'h50; strobe = 1'b1;
    pushByte(8'h77);
    chk("coll_data", {24'd0, dataRead}, 32'hFF);
    chk("coll_flag", {31'd0, rd_collision}, 32'd1);
    tick();
    strobe = 1'b0;
    chk("coll_next_rd", {24'd0, dataRead}, 32'h77);
    chk("coll_sticky", {31'd0, rd_collision}, 32'd1);

    // Reset mid-load
    startLoad(8'h60, 9'd5);
    pushByte(8'hB1);
    pushByte(8'hB2);
    ld_valid = 1'b1; ld_data = 8'hB3;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", {31'd0, ld_ready}, 32'd0);
    chk("mrst_busy", {31'd0, ld_busy}, 32'd0);
    chk("mrst_done", {31'd0, ld_done}, 32'd0);
    chk("mrst_coll", {31'd0, rd_collision}, 32'd0);
    chk("mrst_data", {24'd0, dataRead}, 32'h00);
    tick();
    chk("mrst_done2", {31'd0, ld_done}, 32'd0);
    ld_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    readChk("mrst_rd60", 8'h60, 8'hB1);
    readChk("mrst_rd61", 8'h61, 8'hB2);
    readChk("mrst_rd62", 8'h62, fillAt(8'h62));
    startLoad(8'h70, 9'd1);
    chk("mrst_new_ready", {31'd0, ld_ready}, 32'd1);
    pushByte(8'hC5);
    chk("mrst_new_done", {31'd0, ld_done}, 32'd1);
    tick();
    readChk("mrst_rd70", 8'h70, 8'hC5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
